// File: rtl/chorus_pkg.sv
// Shared types, constants and helpers for the chorus voice engine.
// The triangle fold turns the top of the LFO phase into an 8-bit up/down ramp.
package chorus_pkg;

    localparam int TRI_W = 8;
    localparam int MIX_W = 4;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_TADDR = 3'd2,
        ST_TWAIT = 3'd3,
        ST_TACC  = 3'd4,
        ST_MIX   = 3'd5,
        ST_OUT   = 3'd6
    } chorus_state_e;

    function automatic logic [TRI_W-1:0] tri_fold(input logic fold, input logic [TRI_W-1:0] ramp);
        return fold ? ~ramp : ramp;
    endfunction

endpackage

// File: rtl/chorus_delay_ram.sv
// Simple dual-port delay line storage with a registered read port.
// Contents are deliberately not reset so the array maps onto block RAM.
module chorus_delay_ram #(
    parameter int DEPTH  = 4096,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 12
) (
    input  logic              clk_i,
    input  logic              wrEn_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic [WIDTH-1:0]  wrData_i,
    input  logic              rdEn_i,
    input  logic [ADDR_W-1:0] rdAddr_i,
    output logic [WIDTH-1:0]  rdData_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wrEn_i) mem[wrAddr_i] <= wrData_i;
        if (rdEn_i) rdData_o <= mem[rdAddr_i];
    end

endmodule

// File: rtl/chorus_voice_engine.sv
// Multi-voice chorus: writes each dry sample to a circular buffer, sums one
// LFO-modulated tap per voice, averages them and applies a dry/wet mix.
module chorus_voice_engine
    import chorus_pkg::*;
#(
    parameter int PKT_WIDTH  = 16,
    parameter int NUM_VOICES = 2,
    parameter int BUF_DEPTH  = 4096,
    parameter int AVG_DELAY  = 882,
    parameter int LFO_ACC_W  = 22,
    parameter int RATE_SHIFT = 6
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [PKT_WIDTH-1:0] pkt_i,
    input  logic                 pktChanged_i,
    input  logic [3:0]           rateSetting_i,
    input  logic [3:0]           depthSetting_i,
    input  logic [MIX_W-1:0]     mixSetting_i,
    input  logic                 bypass_i,
    output logic [PKT_WIDTH-1:0] pktMixed_o,
    output logic                 pktMixedChanged_o,
    output logic                 busy_o,
    output logic                 overrunErr_o
);

    localparam int ADDR_W    = $clog2(BUF_DEPTH);
    localparam int AVG_SHIFT = $clog2(NUM_VOICES);
    localparam int VOICE_W   = (NUM_VOICES > 1) ? AVG_SHIFT : 1;
    localparam int ACC_W     = PKT_WIDTH + 2;
    localparam int MIXC_W    = PKT_WIDTH + 5;

    if (!(NUM_VOICES == 1 || NUM_VOICES == 2 || NUM_VOICES == 4)) begin : gBadVoices
        $error("NUM_VOICES must be 1, 2 or 4");
    end
    if ((1 << ADDR_W) != BUF_DEPTH) begin : gBadDepth
        $error("BUF_DEPTH must be a power of 2");
    end
    if (AVG_DELAY + 240 >= BUF_DEPTH) begin : gBadDelay
        $error("AVG_DELAY + 240 must be below BUF_DEPTH");
    end

    chorus_state_e               state_q;
    logic [VOICE_W-1:0]          voice_q;
    logic signed [PKT_WIDTH-1:0] dry_q;
    logic [3:0]                  rate_q;
    logic [3:0]                  depth_q;
    logic [MIX_W-1:0]            mix_q;
    logic                        bypass_q;
    logic [ADDR_W-1:0]           wrPtr_q;
    logic [ADDR_W-1:0]           fillCnt_q;
    logic [LFO_ACC_W-1:0]        phase_q;
    logic signed [ACC_W-1:0]     acc_q;
    logic [ADDR_W-1:0]           rdAddr_q;
    logic                        tapValid_q;
    logic [PKT_WIDTH-1:0]        pktMixed_q;
    logic                        strobe_q;
    logic                        overrun_q;

    logic [PKT_WIDTH-1:0] rdData;

    chorus_delay_ram #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (PKT_WIDTH),
        .ADDR_W(ADDR_W)
    ) uRam (
        .clk_i   (clk_i),
        .wrEn_i  (state_q == ST_WRITE),
        .wrAddr_i(wrPtr_q),
        .wrData_i(dry_q),
        .rdEn_i  (state_q == ST_TWAIT),
        .rdAddr_i(rdAddr_q),
        .rdData_o(rdData)
    );

    // Voices are spread evenly around the LFO cycle.
    logic [LFO_ACC_W-1:0] voiceOfs;
    logic [LFO_ACC_W-1:0] phaseV;
    logic [TRI_W-1:0]     triVal;
    logic [11:0]          modProd;
    logic [7:0]           offset;
    logic [ADDR_W-1:0]    delayV;
    logic [ADDR_W-1:0]    rdAddrNext;

    assign voiceOfs   = LFO_ACC_W'(voice_q) << (LFO_ACC_W - AVG_SHIFT);
    assign phaseV     = phase_q + voiceOfs;
    assign triVal     = tri_fold(phaseV[LFO_ACC_W-1], TRI_W'(phaseV >> (LFO_ACC_W - 1 - TRI_W)));
    assign modProd    = {4'b0, triVal} * {8'b0, depth_q};
    assign offset     = 8'(modProd >> 4);
    assign delayV     = ADDR_W'(AVG_DELAY) + ADDR_W'(offset);
    assign rdAddrNext = wrPtr_q - delayV;

    logic signed [PKT_WIDTH-1:0] rdSigned;
    logic signed [ACC_W-1:0]     tapVal;

    assign rdSigned = signed'(rdData);
    assign tapVal   = tapValid_q ? ACC_W'(rdSigned) : '0;

    logic signed [PKT_WIDTH-1:0] wet;
    logic [MIX_W:0]              dryGain;
    logic signed [MIXC_W-1:0]    dryW;
    logic signed [MIXC_W-1:0]    wetW;
    logic signed [MIXC_W-1:0]    dryGainW;
    logic signed [MIXC_W-1:0]    wetGainW;
    logic signed [MIXC_W-1:0]    mixSum;
    logic signed [PKT_WIDTH-1:0] mixed;

    assign wet      = PKT_WIDTH'(acc_q >>> AVG_SHIFT);
    assign dryGain  = (MIX_W+1)'(2 ** MIX_W) - {1'b0, mix_q};
    assign dryW     = MIXC_W'(dry_q);
    assign wetW     = MIXC_W'(wet);
    assign dryGainW = signed'(MIXC_W'(dryGain));
    assign wetGainW = signed'(MIXC_W'(mix_q));
    assign mixSum   = dryW * dryGainW + wetW * wetGainW;
    assign mixed    = PKT_WIDTH'(mixSum >>> MIX_W);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            voice_q    <= '0;
            dry_q      <= '0;
            rate_q     <= '0;
            depth_q    <= '0;
            mix_q      <= '0;
            bypass_q   <= 1'b0;
            wrPtr_q    <= '0;
            fillCnt_q  <= '0;
            phase_q    <= '0;
            acc_q      <= '0;
            rdAddr_q   <= '0;
            tapValid_q <= 1'b0;
            pktMixed_q <= '0;
            strobe_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            strobe_q <= 1'b0;
            if (pktChanged_i && state_q != ST_IDLE) overrun_q <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (pktChanged_i) begin
                        dry_q    <= signed'(pkt_i);
                        rate_q   <= rateSetting_i;
                        depth_q  <= depthSetting_i;
                        mix_q    <= mixSetting_i;
                        bypass_q <= bypass_i;
                        state_q  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (fillCnt_q != '1) fillCnt_q <= fillCnt_q + 1'b1;
                    acc_q   <= '0;
                    voice_q <= '0;
                    state_q <= ST_TADDR;
                end
                ST_TADDR: begin
                    // fillCnt already counts the sample just written, so a tap
                    // is backed by real data only when fillCnt exceeds its delay.
                    rdAddr_q   <= rdAddrNext;
                    tapValid_q <= fillCnt_q > delayV;
                    state_q    <= ST_TWAIT;
                end
                ST_TWAIT: begin
                    state_q <= ST_TACC;
                end
                ST_TACC: begin
                    acc_q <= acc_q + tapVal;
                    if (voice_q == VOICE_W'(NUM_VOICES - 1)) begin
                        state_q <= ST_MIX;
                    end else begin
                        voice_q <= voice_q + 1'b1;
                        state_q <= ST_TADDR;
                    end
                end
                ST_MIX: begin
                    pktMixed_q <= bypass_q ? dry_q : mixed;
                    strobe_q   <= 1'b1;
                    state_q    <= ST_OUT;
                end
                ST_OUT: begin
                    wrPtr_q <= wrPtr_q + 1'b1;
                    phase_q <= phase_q + (LFO_ACC_W'({1'b0, rate_q} + 5'd1) << RATE_SHIFT);
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pktMixed_o        = pktMixed_q;
    assign pktMixedChanged_o = strobe_q;
    assign busy_o            = (state_q != ST_IDLE);
    assign overrunErr_o      = overrun_q;

endmodule

// File: tb/tb_chorus_voice_engine.sv
// Directed bench for chorus_voice_engine: latency, fill gating, buffer wrap,
// LFO tap placement, mixing, bypass, overrun and mid-frame reset.
module tb_chorus_voice_engine;
    import chorus_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pkt = '0;
    logic        pktChanged = 1'b0;
    logic [3:0]  rate = '0;
    logic [3:0]  depth = '0;
    logic [3:0]  mix = '0;
    logic        bypass = 1'b0;
    logic [15:0] pktMixed;
    logic        pktMixedChanged;
    logic        busy;
    logic        overrunErr;

    int compared = 0;
    int mismatched = 0;

    chorus_voice_engine #(
        .PKT_WIDTH (16),
        .NUM_VOICES(2),
        .BUF_DEPTH (4096),
        .AVG_DELAY (882),
        .LFO_ACC_W (22),
        .RATE_SHIFT(6)
    ) dut (
        .clk_i            (clk),
        .reset_i          (rst),
        .pkt_i            (pkt),
        .pktChanged_i     (pktChanged),
        .rateSetting_i    (rate),
        .depthSetting_i   (depth),
        .mixSetting_i     (mix),
        .bypass_i         (bypass),
        .pktMixed_o       (pktMixed),
        .pktMixedChanged_o(pktMixedChanged),
        .busy_o           (busy),
        .overrunErr_o     (overrunErr)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input int got, input int exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic applyReset();
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Sends one sample and waits (bounded) for its output strobe; lat counts
    // clock edges from the accepting edge, stillHigh is the strobe one edge later.
    task automatic doSample(input logic [15:0] s, output int got, output int lat, output int stillHigh);
        @(negedge clk); pkt = s; pktChanged = 1'b1;
        @(posedge clk); #1; pktChanged = 1'b0;
        got = 0; lat = -1;
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (pktMixedChanged) begin
                lat = k + 1;
                got = int'($signed(pktMixed));
            end
        end
        @(posedge clk); #1;
        stillHigh = int'(pktMixedChanged);
    endtask

    initial begin
        #2_000_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, lat, hi, x, exp, strobes, seen;

        // Reset state and pure-dry passthrough with exact latency.
        applyReset();
        #1;
        checkVal("rst_out", int'(pktMixed), 0);
        checkVal("rst_strobe", int'(pktMixedChanged), 0);
        checkVal("rst_busy", int'(busy), 0);
        checkVal("rst_overrun", int'(overrunErr), 0);
        mix = 4'd0; bypass = 1'b0; depth = 4'd0; rate = 4'd0;
        for (int i = 0; i < 5; i++) begin
            doSample(16'h1000, got, lat, hi);
            checkVal($sformatf("dry%0d_val", i), got, 4096);
            checkVal($sformatf("dry%0d_lat", i), lat, 9);
            checkVal($sformatf("dry%0d_width", i), hi, 0);
            repeat (190) @(posedge clk);
        end

        // Impulse, depth 0, mix 15: dry 1/16 at n=0, wet 15/16 at n=882.
        applyReset();
        mix = 4'd15; depth = 4'd0; rate = 4'd0;
        for (int n = 0; n <= 890; n++) begin
            doSample((n == 0) ? 16'h4000 : 16'h0000, got, lat, hi);
            exp = (n == 0) ? 16'h0400 : (n == 882) ? 16'h3C00 : 0;
            checkVal($sformatf("imp%0d", n), got, exp);
            if (lat != 9) checkVal($sformatf("imp%0d_lat", n), lat, 9);
        end

        // Ramp across the write-pointer wrap.
        applyReset();
        mix = 4'd15; depth = 4'd0; rate = 4'd3;
        for (int n = 0; n < 4300; n++) begin
            doSample(16'(n), got, lat, hi);
            x = (n >= 882) ? n - 882 : 0;
            exp = (n + 15 * x) / 16;
            checkVal($sformatf("ramp%0d", n), got, exp);
            if (lat != 9) checkVal($sformatf("ramp%0d_lat", n), lat, 9);
        end

        // Modulated impulse: depth 15, rate 0 (phase = 64n). Voice 0 reaches
        // slot 0 at n=887 (tri 6, offset 5); voice 1 at n=1113 (tri 247, offset 231).
        applyReset();
        mix = 4'd15; depth = 4'd15; rate = 4'd0;
        for (int n = 0; n <= 1115; n++) begin
            doSample((n == 0) ? 16'h4000 : 16'h0000, got, lat, hi);
            exp = (n == 0) ? 16'h0400 : (n == 887 || n == 1113) ? 16'h1E00 : 0;
            checkVal($sformatf("mod%0d", n), got, exp);
            if (lat != 9) checkVal($sformatf("mod%0d_lat", n), lat, 9);
        end

        // Constant input under full modulation stays constant; then bypass.
        applyReset();
        mix = 4'd8; depth = 4'd15; rate = 4'd15;
        for (int n = 0; n < 1250; n++) begin
            doSample(16'hE000, got, lat, hi);
            if (n >= 1200) checkVal($sformatf("const%0d", n), got, -8192);
        end
        bypass = 1'b1;
        for (int n = 0; n < 3; n++) begin
            doSample(16'h1234, got, lat, hi);
            checkVal($sformatf("bypass%0d", n), got, 16'h1234);
            checkVal($sformatf("bypass%0d_lat", n), lat, 9);
        end
        bypass = 1'b0;

        // Overrun: second strobe three cycles into the frame is dropped.
        applyReset();
        mix = 4'd0; depth = 4'd0;
        strobes = 0; seen = 0;
        @(negedge clk); pkt = 16'h0100; pktChanged = 1'b1;
        @(posedge clk); #1; pktChanged = 1'b0;
        for (int k = 0; k <= 14; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (k == 2) begin
                checkVal("ovr_pre", int'(overrunErr), 0);
                pkt = 16'h7777; pktChanged = 1'b1;
            end
            if (k == 3) pktChanged = 1'b0;
            if (k <= 10) checkVal($sformatf("busy_k%0d", k), int'(busy), (k <= 8) ? 1 : 0);
            if (pktMixedChanged) begin
                strobes++;
                seen = int'($signed(pktMixed));
            end
        end
        checkVal("ovr_strobes", strobes, 1);
        checkVal("ovr_value", seen, 16'h0100);
        checkVal("ovr_sticky", int'(overrunErr), 1);
        repeat (50) @(posedge clk);
        #1 checkVal("ovr_sticky_late", int'(overrunErr), 1);
        applyReset();
        #1 checkVal("ovr_cleared", int'(overrunErr), 0);

        // Reset during TWAIT aborts the frame and clears the fill count.
        mix = 4'd8; depth = 4'd0;
        strobes = 0;
        @(negedge clk); pkt = 16'h1000; pktChanged = 1'b1;
        @(posedge clk); #1; pktChanged = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(posedge clk); #1;
            if (pktMixedChanged) strobes++;
        end
        checkVal("twait_strobes", strobes, 0);
        checkVal("twait_out", int'(pktMixed), 0);
        checkVal("twait_overrun", int'(overrunErr), 0);
        doSample(16'h1000, got, lat, hi);
        checkVal("twait_next_val", got, 16'h0800);
        checkVal("twait_next_lat", lat, 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
